// File: rtl/nexys_starship_prng_pkg.sv
// Shared types and constants for the Nexys Starship pseudo-random event bank.
package nexys_starship_prng_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StCooldown
  } chan_state_e;

  localparam int unsigned ROT_STRIDE = 3;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Right-shift Galois feedback masks; only 16 and 24 bit registers are supported.
  function automatic logic [23:0] tap_mask(input int unsigned width);
    return (width == 24) ? 24'hE10000 : 24'h00B400;
  endfunction

endpackage

// File: rtl/nexys_starship_prng_chan.sv
// One spawn channel: event level held until acknowledged, then an optional cooldown.
module nexys_starship_prng_chan
  import nexys_starship_prng_pkg::*;
#(
  parameter int unsigned CD_W = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            en_i,
  input  logic            hit_i,
  input  logic            ack_i,
  input  logic [CD_W-1:0] cooldown_i,
  output logic            event_o
);

  chan_state_e     state_q, state_d;
  logic [CD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hit_i) state_d = StPending;
      end
      StPending: begin
        if (ack_i) begin
          if (cooldown_i == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StCooldown;
            cnt_d   = cooldown_i;
          end
        end
      end
      StCooldown: begin
        // Counter is frozen while the bank is paused.
        if (en_i) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CD_W'(1)) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign event_o = (state_q == StPending);

endmodule

// File: rtl/nexys_starship_prng_bank.sv
// Shared Galois LFSR feeding NUM_CH probabilistic event channels plus a random nibble.
module nexys_starship_prng_bank
  import nexys_starship_prng_pkg::*;
#(
  parameter int unsigned       NUM_CH   = 8,
  parameter int unsigned       LFSR_W   = 16,
  parameter int unsigned       THRESH_W = 8,
  parameter int unsigned       CD_W     = 8,
  parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(DEFAULT_SEED)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         en_i,
  input  logic                         seed_load_i,
  input  logic [LFSR_W-1:0]            seed_in_i,
  input  logic [NUM_CH*THRESH_W-1:0]   thresh_i,
  input  logic [CD_W-1:0]              cooldown_i,
  input  logic [NUM_CH-1:0]            event_ack_i,
  output logic [NUM_CH-1:0]            event_out_o,
  output logic [3:0]                   random_hex_o,
  output logic [LFSR_W-1:0]            lfsr_state_o
);

  localparam logic [LFSR_W-1:0] TapMask = LFSR_W'(tap_mask(LFSR_W));

  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [3:0]          hex_q, hex_d;
  logic [2*LFSR_W-1:0] lfsr_dbl;

  always_comb begin
    lfsr_d = lfsr_q;
    // A zero seed would lock the LFSR, so fall back to the reset seed.
    if (seed_load_i) begin
      lfsr_d = (seed_in_i == '0) ? SEED : seed_in_i;
    end else if (en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TapMask : '0);
    end
  end

  always_comb begin
    hex_d = hex_q;
    if (en_i) hex_d = lfsr_q[3:0] ^ lfsr_q[LFSR_W-1 -: 4];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q <= SEED;
      hex_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      hex_q  <= hex_d;
    end
  end

  // Doubled register lets a constant part-select implement the rotate-right.
  assign lfsr_dbl = {lfsr_q, lfsr_q};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    localparam int unsigned Rot = (ROT_STRIDE * c) % LFSR_W;

    logic [THRESH_W-1:0] sample;
    logic                hit;

    assign sample = lfsr_dbl[Rot +: THRESH_W];
    assign hit    = en_i && (sample < thresh_i[c*THRESH_W +: THRESH_W]);

    nexys_starship_prng_chan #(
      .CD_W(CD_W)
    ) u_chan (
      .Clk       (Clk),
      .Reset     (Reset),
      .en_i      (en_i),
      .hit_i     (hit),
      .ack_i     (event_ack_i[c]),
      .cooldown_i(cooldown_i),
      .event_o   (event_out_o[c])
    );
  end

  assign random_hex_o = hex_q;
  assign lfsr_state_o = lfsr_q;

endmodule

// File: tb/tb_nexys_starship_prng_bank.sv
// Self-checking bench: vector table, directed corner cases and a random phase against a model.
module tb_nexys_starship_prng_bank;

  localparam int unsigned NCh = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        en;
  logic        seed_load;
  logic [15:0] seed_in;
  logic [63:0] thresh;
  logic [7:0]  cooldown;
  logic [7:0]  ack;
  logic [7:0]  event_out;
  logic [3:0]  hex;
  logic [15:0] lfsr;

  int total = 0;
  int bad   = 0;

  // Reference model state: pending flag and remaining lockout cycles per channel.
  int unsigned m_lfsr;
  int unsigned m_hex;
  bit          m_pend[NCh];
  int          m_cd[NCh];

  nexys_starship_prng_bank dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .en_i        (en),
    .seed_load_i (seed_load),
    .seed_in_i   (seed_in),
    .thresh_i    (thresh),
    .cooldown_i  (cooldown),
    .event_ack_i (ack),
    .event_out_o (event_out),
    .random_hex_o(hex),
    .lfsr_state_o(lfsr)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned ref_step(input int unsigned s);
    return (s >> 1) ^ (((s & 1) != 0) ? 32'hB400 : 32'h0);
  endfunction

  function automatic int unsigned ref_sample(input int unsigned s, input int c);
    int unsigned k, r;
    k = (3 * c) % 16;
    r = ((s >> k) | (s << (16 - k))) & 32'hFFFF;
    return r & 32'hFF;
  endfunction

  function automatic int unsigned model_events();
    int unsigned v = 0;
    for (int c = 0; c < NCh; c++) if (m_pend[c]) v |= (1 << c);
    return v;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 32'hACE1;
    m_hex  = 0;
    for (int c = 0; c < NCh; c++) begin
      m_pend[c] = 1'b0;
      m_cd[c]   = 0;
    end
  endtask

  task automatic model_edge();
    int unsigned s, thr;
    s = m_lfsr;
    for (int c = 0; c < NCh; c++) begin
      thr = 32'(thresh[8*c +: 8]);
      if (m_pend[c]) begin
        if (ack[c]) begin
          m_pend[c] = 1'b0;
          m_cd[c]   = int'(cooldown);
        end
      end else if (m_cd[c] > 0) begin
        if (en) m_cd[c]--;
      end else if (en && ref_sample(s, c) < thr) begin
        m_pend[c] = 1'b1;
      end
    end
    if (en) m_hex = (s & 15) ^ (s >> 12);
    if (seed_load) m_lfsr = (seed_in == 16'h0) ? 32'hACE1 : 32'(seed_in);
    else if (en) m_lfsr = ref_step(s);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge Clk);
    #1;
    check("lfsr", 32'(lfsr), m_lfsr);
    check("event_out", 32'(event_out), model_events());
    check("random_hex", 32'(hex), m_hex);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("reset_lfsr", 32'(lfsr), 32'hACE1);
    check("reset_event", 32'(event_out), 0);
    check("reset_hex", 32'(hex), 0);
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic wait_ev(input int c, input string name);
    int n = 0;
    while (!event_out[c] && n < 40) begin
      cyc();
      n++;
    end
    check(name, 32'(event_out[c]), 1);
  endtask

  typedef struct {
    bit          en;
    bit          ld;
    logic [15:0] sd;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int unsigned exp_bit, frz;
    int fires, diff;
    int cnt[NCh];

    en = 0; seed_load = 0; seed_in = 0; thresh = '0; cooldown = 0; ack = 0; Reset = 0;
    #2;
    do_reset();

    vecs[0] = '{1'b1, 1'b0, 16'h0000, 16'hE270};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 16'h7138};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h7138};
    vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h7138};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'hACE1};
    vecs[5] = '{1'b0, 1'b1, 16'h0001, 16'h0001};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 16'hB400};
    vecs[7] = '{1'b1, 1'b1, 16'h1234, 16'h1234};
    vecs[8] = '{1'b1, 1'b0, 16'h0000, 16'h091A};
    vecs[9] = '{1'b0, 1'b0, 16'h0000, 16'h091A};
    for (int i = 0; i < 10; i++) begin
      en = vecs[i].en; seed_load = vecs[i].ld; seed_in = vecs[i].sd;
      cyc();
      check($sformatf("vec%0d", i), 32'(lfsr), 32'(vecs[i].exp));
    end
    seed_load = 0; en = 0;
    repeat (10) cyc();
    check("hold_en0", 32'(lfsr), 32'h091A);

    // Threshold all-ones on ch0: first sample 8'hE1 fires.
    do_reset();
    thresh[7:0] = 8'hFF; en = 1;
    cyc();
    check("fire_ff", 32'(event_out[0]), 1);

    // Ack with cooldown 4: low for 5 samples even though ch0 would re-fire.
    cooldown = 4; ack = 8'h01;
    cyc();
    ack = 0;
    check("ack_low", 32'(event_out[0]), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("cd_hold", 32'(event_out[0]), 0);
    end
    wait_ev(0, "refire_cd4");

    cooldown = 0; ack = 8'h01;
    cyc();
    ack = 0;
    check("ack_low_cd0", 32'(event_out[0]), 0);
    exp_bit = (ref_sample(m_lfsr, 0) < 255) ? 1 : 0;
    cyc();
    check("refire_cd0", 32'(event_out[0]), exp_bit);

    ack = 8'h08;
    cyc();
    ack = 0;
    check("ack_idle", 32'(event_out[3]), 0);

    // Pause while pending: level held, ack still honoured.
    thresh = '0; thresh[15:8] = 8'hFF; ack = 8'h01;
    cyc();
    ack = 0;
    wait_ev(1, "ch1_fire");
    en = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("pause_hold", 32'(event_out[1]), 1);
    end
    ack = 8'h02;
    cyc();
    ack = 0;
    check("pause_ack", 32'(event_out[1]), 0);

    // Cooldown frozen while paused; a later cooldown change has no effect.
    cooldown = 3; en = 1;
    wait_ev(1, "ch1_fire2");
    ack = 8'h02;
    cyc();
    ack = 0; en = 0;
    frz = m_lfsr;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("cd_frozen", 32'(event_out[1]), 0);
    end
    check("lfsr_frozen", 32'(lfsr), frz);
    cooldown = 0; en = 1;
    cyc();
    check("cd_run1", 32'(event_out[1]), 0);
    cyc();
    check("cd_run2", 32'(event_out[1]), 0);
    cyc();
    wait_ev(1, "ch1_fire3");

    // Asynchronous reset mid-pending.
    #2;
    do_reset();

    // Zero thresholds never fire.
    thresh = '0; en = 1; cooldown = 0;
    fires = 0;
    repeat (4000) begin
      cyc();
      if (event_out != 0) fires++;
    end
    check("zero_thresh", fires, 0);

    // Random phase.
    do_reset();
    thresh = {$urandom, $urandom};
    repeat (3000) begin
      en        = ($urandom_range(0, 9) < 8);
      seed_load = ($urandom_range(0, 49) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      ack       = 8'($urandom);
      if ($urandom_range(0, 19) == 0) cooldown = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 199) == 0) thresh = {$urandom, $urandom};
      cyc();
    end
    seed_load = 0;

    // Rate: p=1/4 with permanent ack; each event costs one pending cycle, so rate is p/(1+p).
    do_reset();
    thresh = {8{8'd64}}; cooldown = 0; ack = 8'hFF; en = 1;
    diff = 0;
    for (int c = 0; c < NCh; c++) cnt[c] = 0;
    repeat (20000) begin
      cyc();
      for (int c = 0; c < NCh; c++) if (event_out[c]) cnt[c]++;
      if (event_out[0] != event_out[1]) diff++;
    end
    for (int c = 0; c < NCh; c++)
      check($sformatf("rate_ch%0d_in_range", c), (cnt[c] > 3200 && cnt[c] < 4800) ? 1 : 0, 1);
    check("channels_distinct", (diff > 0) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
